// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants for the 1024x768@60 raster and small position helpers.
// Every file in the VGA timing slice imports this package.
package vga_timing_gen_pkg;

  localparam int POS_W = 12;
  typedef logic [POS_W-1:0] pos_t;

  localparam int H_ACTIVE_DEF = 1024;
  localparam int H_FP_DEF     = 24;
  localparam int H_SYNC_DEF   = 136;
  localparam int H_BP_DEF     = 160;
  localparam int V_ACTIVE_DEF = 768;
  localparam int V_FP_DEF     = 3;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 29;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // 0 selects active-low sync pulses, the 1024x768@60 convention.
  localparam bit SYNC_POL_DEF = 1'b0;

  function automatic logic inWindow(pos_t pos, int lo, int len);
    return (int'(pos) >= lo) && (int'(pos) < lo + len);
  endfunction

  function automatic logic syncLevel(logic active, bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator (master) and its video consumer (slave).
// The consumer supplies the pixel clock enable and receives position and sync.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  logic pix_en;
  pos_t pixel_column;
  pos_t pixel_row;
  logic video_on;
  logic hsync;
  logic vsync;
  logic frame_tick;

  modport master (
    input  pix_en,
    output pixel_column, pixel_row, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    output pix_en,
    input  pixel_column, pixel_row, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen_counter.sv
// Modulo-N position counter with enable; wrap flags the enabled step from N-1 back to 0.
// Used once for the horizontal and once for the vertical axis.
module timing_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int N = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output pos_t count,
  output logic wrap
);

  logic atMax;

  assign atMax = (count == pos_t'(N - 1));
  assign wrap  = en & atMax;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= atMax ? '0 : count + pos_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v position counters plus registered position, blanking
// and sync decode. Outputs show the counter state from one enabled step earlier.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input logic clock,
  input logic reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  pos_t hCnt;
  pos_t vCnt;
  logic hWrap;
  logic vWrap;
  logic activeArea;
  logic hSyncActive;
  logic vSyncActive;
  logic atFrameStart;

  timing_counter #(.N(H_TOTAL)) hCounter (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (vga.pix_en),
    .count   (hCnt),
    .wrap    (hWrap)
  );

  timing_counter #(.N(V_TOTAL)) vCounter (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (hWrap),
    .count   (vCnt),
    .wrap    (vWrap)
  );

  always_comb begin
    activeArea  = inWindow(hCnt, 0, H_ACTIVE) & inWindow(vCnt, 0, V_ACTIVE);
    hSyncActive = inWindow(hCnt, H_ACTIVE + H_FP, H_SYNC);
    vSyncActive = inWindow(vCnt, V_ACTIVE + V_FP, V_SYNC);
  end

  // Output register stage. atFrameStart remembers that the counters sit at (0,0),
  // which holds after reset and after every vertical wrap, so no full-position compare is needed.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vga.pixel_column <= '0;
      vga.pixel_row    <= '0;
      vga.video_on     <= 1'b0;
      vga.hsync        <= ~SYNC_POL;
      vga.vsync        <= ~SYNC_POL;
      vga.frame_tick   <= 1'b0;
      atFrameStart     <= 1'b1;
    end else begin
      vga.frame_tick <= 1'b0;
      if (vga.pix_en) begin
        vga.pixel_column <= hCnt;
        vga.pixel_row    <= vCnt;
        vga.video_on     <= activeArea;
        vga.hsync        <= syncLevel(hSyncActive, SYNC_POL);
        vga.vsync        <= syncLevel(vSyncActive, SYNC_POL);
        vga.frame_tick   <= atFrameStart;
        atFrameStart     <= vWrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two shrunken rasters (both sync polarities) for
// frame-level behaviour plus a default 1024x768 instance for line-level timing.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } cfgT;

  typedef struct {
    logic [11:0] col;
    logic [11:0] row;
    logic        von, hs, vs, ft;
  } expT;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  vga_timing_gen_if ifS ();
  vga_timing_gen_if ifP ();
  vga_timing_gen_if ifD ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dutS (.clock(clock), .reset_n(reset_n), .vga(ifS));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dutP (.clock(clock), .reset_n(reset_n), .vga(ifP));

  vga_timing_gen dutD (.clock(clock), .reset_n(reset_n), .vga(ifD));

  cfgT   cfg [3];
  int    mh [3];
  int    mv [3];
  expT   last [3];
  expT   sb [$];
  string nm [3] = '{"small", "pol1", "dflt"};

  int vecCount  = 0;
  int missCount = 0;
  int cyc       = 0;
  int tick1     = -1;
  int tick2     = -1;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic expT modelDecode(input cfgT c, input int h, input int v);
    expT e;
    logic hAct, vAct;
    e.col = 12'(h);
    e.row = 12'(v);
    e.von = (h < c.ha) && (v < c.va);
    hAct  = (h >= c.ha + c.hf) && (h <= c.ha + c.hf + c.hs - 1);
    vAct  = (v >= c.va + c.vf) && (v <= c.va + c.vf + c.vs - 1);
    e.hs  = hAct ? c.pol : !c.pol;
    e.vs  = vAct ? c.pol : !c.pol;
    e.ft  = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic expT sampleDut(input int k);
    expT a;
    case (k)
      0:       a = '{ifS.pixel_column, ifS.pixel_row, ifS.video_on, ifS.hsync, ifS.vsync, ifS.frame_tick};
      1:       a = '{ifP.pixel_column, ifP.pixel_row, ifP.video_on, ifP.hsync, ifP.vsync, ifP.frame_tick};
      default: a = '{ifD.pixel_column, ifD.pixel_row, ifD.video_on, ifD.hsync, ifD.vsync, ifD.frame_tick};
    endcase
    return a;
  endfunction

  // One clock: predict every DUT's registered outputs, push them, then compare after the edge.
  task automatic step(input bit en, input bit rstn);
    expT e, a;
    int  ht, vt;
    ifS.pix_en = en;
    ifP.pix_en = en;
    ifD.pix_en = en;
    reset_n    = rstn;
    for (int k = 0; k < 3; k++) begin
      ht = cfg[k].ha + cfg[k].hf + cfg[k].hs + cfg[k].hb;
      vt = cfg[k].va + cfg[k].vf + cfg[k].vs + cfg[k].vb;
      if (!rstn) begin
        e = '{12'd0, 12'd0, 1'b0, !cfg[k].pol, !cfg[k].pol, 1'b0};
        mh[k] = 0;
        mv[k] = 0;
      end else if (en) begin
        e = modelDecode(cfg[k], mh[k], mv[k]);
        if (mh[k] == ht - 1) begin
          mh[k] = 0;
          mv[k] = (mv[k] == vt - 1) ? 0 : mv[k] + 1;
        end else begin
          mh[k] = mh[k] + 1;
        end
      end else begin
        e    = last[k];
        e.ft = 1'b0;
      end
      last[k] = e;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      a = sampleDut(k);
      checkEq({nm[k], ".col"},  32'(a.col), 32'(e.col));
      checkEq({nm[k], ".row"},  32'(a.row), 32'(e.row));
      checkEq({nm[k], ".von"},  32'(a.von), 32'(e.von));
      checkEq({nm[k], ".hs"},   32'(a.hs),  32'(e.hs));
      checkEq({nm[k], ".vs"},   32'(a.vs),  32'(e.vs));
      checkEq({nm[k], ".tick"}, 32'(a.ft),  32'(e.ft));
    end
    if (ifS.frame_tick === 1'b1) begin
      if (tick1 < 0)      tick1 = cyc;
      else if (tick2 < 0) tick2 = cyc;
    end
  endtask

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit found;

    cfg[0] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0};
    cfg[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b1};
    cfg[2] = '{H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
               V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF, SYNC_POL_DEF};
    for (int k = 0; k < 3; k++) begin
      mh[k]   = 0;
      mv[k]   = 0;
      last[k] = '{12'd0, 12'd0, 1'b0, !cfg[k].pol, !cfg[k].pol, 1'b0};
    end
    ifS.pix_en = 1'b0;
    ifP.pix_en = 1'b0;
    ifD.pix_en = 1'b0;

    // Reset with the enable both low and high: reset must win.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Continuous scan: two full small frames, tick spacing measured on the small raster.
    tick1 = -1;
    tick2 = -1;
    for (int i = 0; i < 250; i++) step(1'b1, 1'b1);
    checkEq("tickPeriod", 32'(tick2 - tick1), 32'd120);

    // Enable pattern 1,0,0,1 repeated.
    for (int i = 0; i < 240; i++) step(pat[i % 4], 1'b1);

    // Walk the small raster to (5,5), inside its vsync band, then reset mid-frame.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mh[0] == 5 && mv[0] == 5) found = 1'b1;
      else step(1'b1, 1'b1);
    end
    checkEq("seekVsync", 32'(found), 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    // Restart all rasters and sweep past one full default line and its wrap.
    step(1'b1, 1'b0);
    for (int i = 0; i < 1400; i++) step(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 Parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 Parameter V_FP, default 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BP, default 29, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 clock  input  1  pixel-domain clock, rising edge.
REQ-011 reset_n  input  1  reset, synchronous, active-low.
REQ-012 pix_en  input  1  pixel clock enable; one pixel step per high cycle.
REQ-013 pixel_column  output  12  current horizontal position, 0..H_TOTAL-1.
REQ-014 pixel_row  output  12  current vertical position, 0..V_TOTAL-1.
REQ-015 video_on  output  1  high while position is inside the active area.
REQ-016 hsync  output  1  horizontal sync, level per SYNC_POL.
REQ-017 vsync  output  1  vertical sync, level per SYNC_POL.
REQ-018 frame_tick  output  1  single-clock pulse at start of each frame.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806); all position arithmetic is 12-bit unsigned.
REQ-020 Internal counters h_cnt and v_cnt advance only on clocks with pix_en=1; with pix_en=0, counters and all outputs except frame_tick hold.
REQ-021 h_cnt wraps from H_TOTAL-1 to 0; v_cnt increments only on that wrap.
REQ-022 On the same clock, h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 wrap both counters to 0.
REQ-023 All outputs are registered: on each pix_en=1 clock, outputs load the decode of the pre-increment (h_cnt, v_cnt), so outputs lag the counters by one enabled step.
REQ-024 pixel_column = h_cnt and pixel_row = v_cnt, including blanking positions, so downstream comparators see values >= active size during blanking.
REQ-025 video_on = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-026 hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (default 1048..1183) on every line, and inactive otherwise.
REQ-027 vsync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (default 771..776) across the full line, and inactive otherwise.
REQ-028 frame_tick is high for exactly one clock, namely the clock whose pix_en update loads position (0,0); it is low on all other clocks, including pix_en=0 clocks.

Reset
REQ-029 While reset_n=0 at a rising edge: h_cnt=0, v_cnt=0, pixel_column=0, pixel_row=0, video_on=0, frame_tick=0, hsync=vsync=~SYNC_POL (inactive).
REQ-030 Reset takes priority over pix_en; asserting reset mid-frame aborts the frame and restarts at (0,0) with no partial sync pulse held.
REQ-031 The first pix_en=1 clock after reset release loads (0,0), video_on=1, and frame_tick=1.

Structure
REQ-032 A shared package holds the default 1024x768@60 timing constants, the H_TOTAL/V_TOTAL derivations, and the sync-polarity constant.
REQ-033 One sub-module, timing_counter (a parameterized modulo-N counter with enable and wrap output), is instantiated twice, horizontally and vertically.

Verification
REQ-034 Reset, then pix_en=1 continuous -> first update gives col=0, row=0, video_on=1, frame_tick=1; the next frame_tick arrives exactly 1344*806=1,083,264 clocks later.
REQ-035 Line scan, pix_en=1 -> hsync low exactly for col 1048..1183 (136 clocks); video_on drops at col 1024; col returns 1343->0 and row increments.
REQ-036 Frame scan -> vsync low for rows 771..776 (6*1344 clocks); video_on=0 for all rows >= 768; (1343,805) is followed by (0,0).
REQ-037 pix_en toggled 1,0,0,1 repeatedly -> position advances one step per enabled clock; outputs hold on disabled clocks; frame_tick never exceeds one clock.
REQ-038 reset_n=0 asserted at (500,771) during vsync -> next clock shows vsync=1, hsync=1, video_on=0; after release the scan restarts at (0,0).
REQ-039 SYNC_POL=1 build -> hsync and vsync are high only inside the REQ-026/027 windows; reset drives them low.
